// File: rtl/lc3_wb_sequencer.sv
// lc3_wb_sequencer: LC3 writeback sequencer with 8x16 register file, NZP flags and load-wait timeout.
// Optional same-cycle read forwarding of the commit data when WB_BYPASS_EN is defined.
module lc3_wb_sequencer #(
  parameter int MEM_TIMEOUT = 8,
  parameter int TCNT_W      = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_writeback,
  input  logic [1:0]  W_control_in,
  input  logic [15:0] aluout,
  input  logic [15:0] memout,
  input  logic [15:0] pcout,
  input  logic [15:0] npc,
  input  logic [2:0]  dr,
  input  logic [2:0]  sr1,
  input  logic [2:0]  sr2,
  input  logic        mem_valid,
  output logic [15:0] VSR1,
  output logic [15:0] VSR2,
  output logic [2:0]  psr,
  output logic        wb_busy,
  output logic        wb_done,
  output logic        wb_error,
  output logic [15:0] wb_npc
);
  typedef enum logic {IDLE, WAIT_MEM} state_t;
  state_t r_state, w_next;
  logic [15:0] r_rf [8];
  logic [15:0] r_npc, w_data;
  logic [TCNT_W-1:0] r_cnt;
  logic [2:0] r_dr, r_psr, w_tgt, w_psr;
  logic r_done, r_error, w_req, w_last, w_commit, w_err, w_wait;
  always_comb begin
    w_wait   = r_state == WAIT_MEM;
    w_req    = !w_wait && enable_writeback;
    w_last   = r_cnt == TCNT_W'(MEM_TIMEOUT - 1);
    w_commit = w_wait ? mem_valid : w_req && W_control_in != 2'd3 && (W_control_in != 2'd1 || mem_valid);
    w_err    = w_wait ? !mem_valid && w_last : w_req && W_control_in == 2'd3;
    w_next   = w_wait ? ((mem_valid || w_last) ? IDLE : WAIT_MEM)
                      : ((w_req && W_control_in == 2'd1 && !mem_valid) ? WAIT_MEM : IDLE);
    w_data   = (w_wait || W_control_in == 2'd1) ? memout : W_control_in == 2'd0 ? aluout : pcout;
    w_tgt    = w_wait ? r_dr : dr;
    w_psr    = {w_data[15], w_data == 16'h0000, !w_data[15] && w_data != 16'h0000};
  end
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) r_rf[i] <= '0;
      r_psr   <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_npc   <= '0;
      r_cnt   <= '0;
      r_dr    <= '0;
    end else begin
      r_done  <= w_commit;
      r_error <= w_err;
      r_cnt   <= w_wait ? r_cnt + TCNT_W'(1) : '0;
      if (w_req) begin
        r_npc <= npc;
        r_dr  <= dr;
      end
      if (w_commit) begin
        r_rf[w_tgt] <= w_data;
        r_psr       <= w_psr;
      end
    end
  end
`ifdef WB_BYPASS_EN
  assign VSR1 = (w_commit && w_tgt == sr1) ? w_data : r_rf[sr1];
  assign VSR2 = (w_commit && w_tgt == sr2) ? w_data : r_rf[sr2];
`else
  assign VSR1 = r_rf[sr1];
  assign VSR2 = r_rf[sr2];
`endif
  assign psr      = r_psr;
  assign wb_busy  = w_wait;
  assign wb_done  = r_done;
  assign wb_error = r_error;
  assign wb_npc   = r_npc;
endmodule

// File: tb/tb_lc3_wb_sequencer.sv
// tb_lc3_wb_sequencer: directed vector table plus hand sequences for load wait, timeout, reset and forwarding.
module tb_lc3_wb_sequencer;
  logic clk = 1'b0, rst;
  logic en, mv;
  logic [1:0] w;
  logic [15:0] alu, mem, pc, npc;
  logic [2:0] dr, sr1, sr2;
  logic [15:0] v1, v2, o_npc;
  logic [2:0] o_psr;
  logic busy, done, err;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  lc3_wb_sequencer dut (
    .clock(clk), .reset(rst), .enable_writeback(en), .W_control_in(w),
    .aluout(alu), .memout(mem), .pcout(pc), .npc(npc), .dr(dr), .sr1(sr1), .sr2(sr2),
    .mem_valid(mv), .VSR1(v1), .VSR2(v2), .psr(o_psr), .wb_busy(busy), .wb_done(done),
    .wb_error(err), .wb_npc(o_npc)
  );
  typedef struct {
    logic en; logic [1:0] w; logic [15:0] alu, mem, pc, npc;
    logic [2:0] dr, sr1, sr2; logic mv;
    logic [2:0] e_psr; logic e_done, e_err, e_busy; logic [15:0] e_v1, e_v2, e_npc;
  } vec_t;
  vec_t tv [10];
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic edge_idle;
    @(posedge clk);
    #1;
    en = 1'b0;
    mv = 1'b0;
    #1;
  endtask
  initial begin
    logic [15:0] byp_exp;
    int k;
    tv[0] = '{1'b1, 2'd0, 16'h8001, 16'h0000, 16'h0000, 16'h3001, 3'd3, 3'd3, 3'd0, 1'b0, 3'b100, 1'b1, 1'b0, 1'b0, 16'h8001, 16'h0000, 16'h3001};
    tv[1] = '{1'b1, 2'd2, 16'h5555, 16'h0000, 16'h0000, 16'h3002, 3'd4, 3'd4, 3'd3, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h8001, 16'h3002};
    tv[2] = '{1'b0, 2'd0, 16'h7777, 16'h0000, 16'h0000, 16'h3099, 3'd3, 3'd3, 3'd4, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 16'h8001, 16'h0000, 16'h3002};
    tv[3] = '{1'b1, 2'd1, 16'h0001, 16'h0042, 16'h0002, 16'h3003, 3'd1, 3'd1, 3'd3, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 16'h0042, 16'h8001, 16'h3003};
    tv[4] = '{1'b1, 2'd3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h3004, 3'd1, 3'd1, 3'd0, 1'b1, 3'b001, 1'b0, 1'b1, 1'b0, 16'h0042, 16'h0000, 16'h3004};
    tv[5] = '{1'b1, 2'd0, 16'hFFFF, 16'h0000, 16'h0000, 16'h3005, 3'd7, 3'd7, 3'd7, 1'b0, 3'b100, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h3005};
    tv[6] = '{1'b1, 2'd1, 16'h0000, 16'h1234, 16'h0000, 16'h3006, 3'd5, 3'd5, 3'd7, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 16'h3006};
    tv[7] = '{1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h3007, 3'd0, 3'd5, 3'd7, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 16'h3006};
    tv[8] = '{1'b1, 2'd0, 16'h1111, 16'h0000, 16'h0000, 16'h3008, 3'd0, 3'd5, 3'd0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h3006};
    tv[9] = '{1'b0, 2'd0, 16'h0000, 16'h0042, 16'h0000, 16'h3009, 3'd0, 3'd5, 3'd0, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 16'h0042, 16'h0000, 16'h3006};
    rst = 1'b1; en = 1'b0; mv = 1'b0; w = '0; alu = '0; mem = '0; pc = '0; npc = '0;
    dr = '0; sr1 = '0; sr2 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int r = 0; r < 8; r++) begin
      sr1 = 3'(r);
      sr2 = 3'(7 - r);
      #1;
      chk($sformatf("reset VSR1[%0d]", r), v1, 16'h0000);
      chk($sformatf("reset VSR2[%0d]", 7 - r), v2, 16'h0000);
    end
    chk("reset psr", {13'd0, o_psr}, 16'h0000);
    chk("reset busy", {15'd0, busy}, 16'h0000);
    chk("reset done", {15'd0, done}, 16'h0000);
    chk("reset error", {15'd0, err}, 16'h0000);
    chk("reset npc", o_npc, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      en = tv[i].en; w = tv[i].w; alu = tv[i].alu; mem = tv[i].mem; pc = tv[i].pc;
      npc = tv[i].npc; dr = tv[i].dr; sr1 = tv[i].sr1; sr2 = tv[i].sr2; mv = tv[i].mv;
      edge_idle();
      chk($sformatf("v%0d psr", i), {13'd0, o_psr}, {13'd0, tv[i].e_psr});
      chk($sformatf("v%0d done", i), {15'd0, done}, {15'd0, tv[i].e_done});
      chk($sformatf("v%0d error", i), {15'd0, err}, {15'd0, tv[i].e_err});
      chk($sformatf("v%0d busy", i), {15'd0, busy}, {15'd0, tv[i].e_busy});
      chk($sformatf("v%0d VSR1", i), v1, tv[i].e_v1);
      chk($sformatf("v%0d VSR2", i), v2, tv[i].e_v2);
      chk($sformatf("v%0d npc", i), o_npc, tv[i].e_npc);
    end
    // load that never gets mem_valid: error on the 8th edge spent in WAIT_MEM
    en = 1'b1; w = 2'd1; mv = 1'b0; dr = 3'd6; sr1 = 3'd6; npc = 16'h4000;
    edge_idle();
    chk("timeout entry busy", {15'd0, busy}, 16'h0001);
    k = 0;
    for (int c = 1; c <= 20 && k == 0; c++) begin
      @(posedge clk);
      #1;
      if (err) k = c;
    end
    chk("timeout edge count", 16'(k), 16'd8);
    chk("timeout busy", {15'd0, busy}, 16'h0000);
    chk("timeout done", {15'd0, done}, 16'h0000);
    chk("timeout rf6", v1, 16'h0000);
    chk("timeout psr", {13'd0, o_psr}, 16'h0001);
    // same load, mem_valid arrives on the last allowed cycle
    en = 1'b1; w = 2'd1; mv = 1'b0; dr = 3'd6; mem = 16'h8000;
    edge_idle();
    repeat (7) @(posedge clk);
    #1;
    chk("lastcycle busy", {15'd0, busy}, 16'h0001);
    chk("lastcycle no early error", {15'd0, err}, 16'h0000);
    mv = 1'b1;
    edge_idle();
    chk("lastcycle done", {15'd0, done}, 16'h0001);
    chk("lastcycle error", {15'd0, err}, 16'h0000);
    chk("lastcycle busy clear", {15'd0, busy}, 16'h0000);
    chk("lastcycle rf6", v1, 16'h8000);
    chk("lastcycle psr", {13'd0, o_psr}, 16'h0004);
    // reset while waiting must discard the pending write
    en = 1'b1; w = 2'd1; mv = 1'b0; dr = 3'd2; sr1 = 3'd2; mem = 16'h5555;
    edge_idle();
    chk("rstwait busy", {15'd0, busy}, 16'h0001);
    rst = 1'b1;
    mv = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rstwait busy clear", {15'd0, busy}, 16'h0000);
    chk("rstwait done", {15'd0, done}, 16'h0000);
    chk("rstwait rf2", v1, 16'h0000);
    chk("rstwait psr", {13'd0, o_psr}, 16'h0000);
    mv = 1'b0;
    // forwarding of the commit data to a same-cycle read
`ifdef WB_BYPASS_EN
    byp_exp = 16'h1234;
`else
    byp_exp = 16'h0000;
`endif
    en = 1'b1; w = 2'd0; dr = 3'd2; sr1 = 3'd2; alu = 16'h1234;
    #1;
    chk("bypass VSR1 commit cycle", v1, byp_exp);
    edge_idle();
    chk("bypass VSR1 after", v1, 16'h1234);
    chk("bypass psr", {13'd0, o_psr}, 16'h0001);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
